// File: rtl/scarv_cop_mem_pkg.sv
// rtl/scarv_cop_mem_pkg.sv - shared types, constants and range helper for the COP memory responder
package scarv_cop_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_t;

  // Fibonacci feedback taps 16,14,13,11 (bits 15,13,12,10)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          BYTE_W    = 8;
  localparam int          N_LANES   = 4;

  // Words below the base wrap to a large offset and therefore fail.
  function automatic logic addr_in_range(input logic [29:0] word_addr,
                                         input logic [29:0] base_word,
                                         input int unsigned depth_log2);
    logic [29:0] off;
    off = word_addr - base_word;
    return {1'b0, off} < (31'd1 << depth_log2);
  endfunction

endpackage

// File: rtl/scarv_cop_mem_responder_if.sv
// rtl/scarv_cop_mem_responder_if.sv - COP memory request/response bundle with requester and responder views
interface scarv_cop_mem_responder_if;
  logic        cop_mem_cen;
  logic        cop_mem_wen;
  logic [31:0] cop_mem_addr;
  logic [31:0] cop_mem_wdata;
  logic [3:0]  cop_mem_ben;
  logic [31:0] cop_mem_rdata;
  logic        cop_mem_stall;
  logic        cop_mem_error;

  modport master (
    output cop_mem_cen, cop_mem_wen, cop_mem_addr, cop_mem_wdata, cop_mem_ben,
    input  cop_mem_rdata, cop_mem_stall, cop_mem_error
  );

  modport slave (
    input  cop_mem_cen, cop_mem_wen, cop_mem_addr, cop_mem_wdata, cop_mem_ben,
    output cop_mem_rdata, cop_mem_stall, cop_mem_error
  );
endinterface

// File: rtl/scarv_cop_mem_stall_gen.sv
// rtl/scarv_cop_mem_stall_gen.sv - LFSR-driven stall length generator with down-counter
module scarv_cop_mem_stall_gen
  import scarv_cop_mem_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       g_clk,
  input  logic       g_reset,
  input  logic       load,
  input  logic [3:0] cfg_stall_max,
  output logic       stall,
  output logic       load_zero,
  output logic       cnt_last
);

  logic [15:0] lfsr;
  logic [3:0]  cnt;
  logic [3:0]  load_val;

  always_comb begin
    load_val = 4'(({1'b0, lfsr[3:0]}) % ({1'b0, cfg_stall_max} + 5'd1));
  end

  assign load_zero = (load_val == 4'd0);
  assign stall     = (cnt != 4'd0);
  assign cnt_last  = (cnt == 4'd1);

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      lfsr <= LFSR_SEED;
      cnt  <= 4'd0;
    end else if (load) begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
      cnt  <= load_val;
    end else if (cnt != 4'd0) begin
      cnt  <= cnt - 4'd1;
    end
  end

endmodule

// File: rtl/scarv_cop_mem_responder.sv
// rtl/scarv_cop_mem_responder.sv - COP memory responder with random stalls; SCARV_MEM_RESP_FAULT_EN adds fault_inject
module scarv_cop_mem_responder
  import scarv_cop_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                            g_clk,
  input  logic                            g_reset,
  scarv_cop_mem_responder_if.slave        mem,
  input  logic [3:0]                      cfg_stall_max,
  output logic [31:0]                     txn_count
`ifdef SCARV_MEM_RESP_FAULT_EN
  ,
  input  logic                            fault_inject
`endif
);

  localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

  mem_state_t state_q, state_d;

  logic        accept;
  logic        load_zero, cnt_last, gen_stall;

  logic [29:0] req_word_q;
  logic        req_wen_q;
  logic [31:0] req_wdata_q;
  logic [3:0]  req_ben_q;
  logic        req_fault;

  logic [29:0] src_word;
  logic        src_wen;
  logic        src_fault;
  logic [29:0] src_off, req_off;
  logic [DEPTH_LOG2-1:0] src_idx, req_idx;
  logic        src_ok, req_ok, commit;

  logic [31:0] mem_arr [2**DEPTH_LOG2];
  logic [31:0] fwd_word;
  logic [31:0] rdata_q;
  logic        error_q;
  logic        unused_bits;

  assign accept = mem.cop_mem_cen && (state_q == ST_IDLE || state_q == ST_RESP);

  scarv_cop_mem_stall_gen #(.LFSR_SEED(LFSR_SEED)) u_stall_gen (
    .g_clk        (g_clk),
    .g_reset      (g_reset),
    .load         (accept),
    .cfg_stall_max(cfg_stall_max),
    .stall        (gen_stall),
    .load_zero    (load_zero),
    .cnt_last     (cnt_last)
  );

`ifdef SCARV_MEM_RESP_FAULT_EN
  logic req_fault_q;
  always_ff @(posedge g_clk) begin
    if (g_reset)     req_fault_q <= 1'b0;
    else if (accept) req_fault_q <= fault_inject;
  end
  assign req_fault = req_fault_q;
  assign src_fault = accept ? fault_inject : req_fault_q;
`else
  assign req_fault = 1'b0;
  assign src_fault = 1'b0;
`endif

  // The transaction entering RESP is the live request on a zero-stall accept, else the latched one.
  assign src_word = accept ? mem.cop_mem_addr[31:2] : req_word_q;
  assign src_wen  = accept ? mem.cop_mem_wen        : req_wen_q;
  assign src_off  = src_word - BASE_WORD;
  assign req_off  = req_word_q - BASE_WORD;
  assign src_idx  = src_off[DEPTH_LOG2-1:0];
  assign req_idx  = req_off[DEPTH_LOG2-1:0];
  assign src_ok   = addr_in_range(src_word, BASE_WORD, DEPTH_LOG2) && !src_fault;
  assign req_ok   = addr_in_range(req_word_q, BASE_WORD, DEPTH_LOG2) && !req_fault;
  assign commit   = (state_q == ST_RESP) && req_wen_q && req_ok;

  assign unused_bits = ^{mem.cop_mem_addr[1:0], src_off[29:DEPTH_LOG2], req_off[29:DEPTH_LOG2]};

  // A read entering RESP on the edge a write commits must see the merged word.
  always_comb begin
    fwd_word = mem_arr[src_idx];
    for (int l = 0; l < N_LANES; l++) begin
      if (commit && req_idx == src_idx && req_ben_q[l]) begin
        fwd_word[l*BYTE_W +: BYTE_W] = req_wdata_q[l*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) state_d = load_zero ? ST_RESP : ST_WAIT;
        else        state_d = ST_IDLE;
      end
      ST_WAIT: begin
        if (cnt_last) state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q     <= ST_IDLE;
      rdata_q     <= 32'd0;
      error_q     <= 1'b0;
      txn_count   <= 32'd0;
      req_word_q  <= 30'd0;
      req_wen_q   <= 1'b0;
      req_wdata_q <= 32'd0;
      req_ben_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_word_q  <= mem.cop_mem_addr[31:2];
        req_wen_q   <= mem.cop_mem_wen;
        req_wdata_q <= mem.cop_mem_wdata;
        req_ben_q   <= mem.cop_mem_ben;
      end
      if (state_d == ST_RESP) begin
        rdata_q <= (!src_wen && src_ok) ? fwd_word : 32'd0;
        error_q <= !src_ok;
      end else begin
        rdata_q <= 32'd0;
        error_q <= 1'b0;
      end
      if (state_q == ST_RESP) txn_count <= txn_count + 32'd1;
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_reset && commit) begin
      for (int l = 0; l < N_LANES; l++) begin
        if (req_ben_q[l]) mem_arr[req_idx][l*BYTE_W +: BYTE_W] <= req_wdata_q[l*BYTE_W +: BYTE_W];
      end
    end
  end

  assign mem.cop_mem_rdata = rdata_q;
  assign mem.cop_mem_error = error_q;
  assign mem.cop_mem_stall = gen_stall;

endmodule

// File: tb/tb_scarv_cop_mem_responder.sv
// tb/tb_scarv_cop_mem_responder.sv - scoreboard bench for the COP memory responder
module tb_scarv_cop_mem_responder;

  localparam logic [31:0] BASE      = 32'h0000_1000;
  localparam logic [29:0] BASE_WORD = 30'(BASE >> 2);
  localparam int          DL2       = 6;
  localparam int          WORDS     = 1 << DL2;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic [3:0]  cfg_stall_max;
  logic [31:0] txn_count;

  scarv_cop_mem_responder_if mem_if();

  always #5 g_clk = ~g_clk;

  scarv_cop_mem_responder #(
    .BASE_ADDR (BASE),
    .DEPTH_LOG2(DL2),
    .LFSR_SEED (16'hACE1)
  ) dut (
    .g_clk        (g_clk),
    .g_reset      (g_reset),
    .mem          (mem_if),
    .cfg_stall_max(cfg_stall_max),
    .txn_count    (txn_count)
`ifdef SCARV_MEM_RESP_FAULT_EN
    ,
    .fault_inject (1'b0)
`endif
  );

  typedef struct {
    logic [31:0] rdata;
    logic        error;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [WORDS];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_txn  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic issue(input logic wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] ben);
    exp_t        e;
    logic [29:0] off;
    logic        inr;
    int          idx;
    mem_if.cop_mem_cen   = 1'b1;
    mem_if.cop_mem_wen   = wen;
    mem_if.cop_mem_addr  = addr;
    mem_if.cop_mem_wdata = wdata;
    mem_if.cop_mem_ben   = ben;
    off = addr[31:2] - BASE_WORD;
    inr = off < 30'(WORDS);
    idx = int'(off[DL2-1:0]);
    e.rdata = 32'd0;
    e.error = !inr;
    if (inr) begin
      if (wen) begin
        for (int l = 0; l < 4; l++)
          if (ben[l]) model[idx][l*8 +: 8] = wdata[l*8 +: 8];
      end else begin
        e.rdata = model[idx];
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_resp(input int max_stall);
    exp_t e;
    int   len;
    len = 0;
    @(posedge g_clk); #1;
    while (mem_if.cop_mem_stall === 1'b1 && len < 40) begin
      len++;
      @(posedge g_clk); #1;
    end
    check("stall_len_ok", 32'(len <= max_stall), 32'd1);
    e = exp_q.pop_front();
    check("rdata", mem_if.cop_mem_rdata, e.rdata);
    check("error", 32'(mem_if.cop_mem_error), 32'(e.error));
    exp_txn++;
  endtask

  task automatic txn(input logic wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] ben);
    issue(wen, addr, wdata, ben);
    wait_resp(int'(cfg_stall_max));
  endtask

  task automatic idle();
    mem_if.cop_mem_cen = 1'b0;
    @(posedge g_clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_txn;
    g_reset              = 1'b1;
    cfg_stall_max        = 4'd0;
    mem_if.cop_mem_cen   = 1'b0;
    mem_if.cop_mem_wen   = 1'b0;
    mem_if.cop_mem_addr  = 32'd0;
    mem_if.cop_mem_wdata = 32'd0;
    mem_if.cop_mem_ben   = 4'd0;
    repeat (2) @(posedge g_clk);
    #1;
    check("rst_rdata", mem_if.cop_mem_rdata, 32'd0);
    check("rst_stall", 32'(mem_if.cop_mem_stall), 32'd0);
    check("rst_error", 32'(mem_if.cop_mem_error), 32'd0);
    check("rst_txn", txn_count, 32'd0);
    g_reset = 1'b0;

    // single-cycle write then read
    cfg_stall_max = 4'd0;
    txn(1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF);
    idle();
    txn(1'b0, BASE + 32'h10, 32'd0, 4'hF);
    check("read_deadbeef", mem_if.cop_mem_rdata, 32'hDEADBEEF);
    idle();
    check("txn_two", txn_count, 32'd2);

    // partial byte-enable merge
    txn(1'b1, BASE + 32'h20, 32'h11223344, 4'hF);
    idle();
    txn(1'b1, BASE + 32'h20, 32'hAABBCCDD, 4'b0101);
    idle();
    txn(1'b0, BASE + 32'h20, 32'd0, 4'hF);
    check("ben_merge", mem_if.cop_mem_rdata, 32'h11BB33DD);
    idle();

    // back-to-back write then read exercising the forwarding path
    txn(1'b1, BASE + 32'h30, 32'hCAFEF00D, 4'hF);
    txn(1'b0, BASE + 32'h30, 32'd0, 4'hF);
    check("fwd_full", mem_if.cop_mem_rdata, 32'hCAFEF00D);
    txn(1'b1, BASE + 32'h30, 32'h98765432, 4'b1100);
    txn(1'b0, BASE + 32'h30, 32'd0, 4'hF);
    check("fwd_partial", mem_if.cop_mem_rdata, 32'h9876F00D);
    txn(1'b1, BASE + 32'h30, 32'h0, 4'b0000);
    txn(1'b0, BASE + 32'h30, 32'd0, 4'hF);
    check("ben_zero", mem_if.cop_mem_rdata, 32'h9876F00D);
    idle();
    check("txn_mid", txn_count, 32'(exp_txn));

    // random stalls: fill window, then 100 random reads
    cfg_stall_max = 4'd15;
    for (int i = 0; i < WORDS; i++) txn(1'b1, BASE + 32'(4 * i), $urandom, 4'hF);
    idle();
    start_txn = exp_txn;
    for (int i = 0; i < 100; i++) begin
      txn(1'b0, BASE + 32'(4 * $urandom_range(0, WORDS - 1)), 32'd0, 4'hF);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    check("txn_rand", txn_count, 32'(start_txn + 100));

    // out-of-range accesses above and below the window
    cfg_stall_max = 4'd3;
    txn(1'b0, BASE + 32'(4 * WORDS), 32'd0, 4'hF);
    txn(1'b0, BASE - 32'd4, 32'd0, 4'hF);
    txn(1'b1, BASE + 32'(4 * WORDS), 32'h55555555, 4'hF);
    txn(1'b0, BASE + 32'h10, 32'd0, 4'hF);
    idle();

    // reset during WAIT abandons the write
    cfg_stall_max = 4'd0;
    txn(1'b1, BASE, 32'h5A5A0001, 4'hF);
    idle();
    g_reset = 1'b1;
    @(posedge g_clk); #1;
    g_reset = 1'b0;
    exp_txn = 0;
    check("txn_after_rst", txn_count, 32'd0);
    cfg_stall_max = 4'd15;
    // seed low nibble is 1, so the first accept stalls for exactly one cycle
    mem_if.cop_mem_cen   = 1'b1;
    mem_if.cop_mem_wen   = 1'b1;
    mem_if.cop_mem_addr  = BASE;
    mem_if.cop_mem_wdata = 32'hFFFFFFFF;
    mem_if.cop_mem_ben   = 4'hF;
    @(posedge g_clk); #1;
    check("seed_stall", 32'(mem_if.cop_mem_stall), 32'd1);
    g_reset = 1'b1;
    @(posedge g_clk); #1;
    check("rst_wait_stall", 32'(mem_if.cop_mem_stall), 32'd0);
    check("rst_wait_rdata", mem_if.cop_mem_rdata, 32'd0);
    g_reset            = 1'b0;
    mem_if.cop_mem_cen = 1'b0;
    @(posedge g_clk); #1;
    check("rst_wait_txn", txn_count, 32'd0);
    cfg_stall_max = 4'd0;
    txn(1'b0, BASE, 32'd0, 4'hF);
    check("pre_write_kept", mem_if.cop_mem_rdata, 32'h5A5A0001);
    idle();
    check("txn_final", txn_count, 32'(exp_txn));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scarv_cop_mem_responder.md
Name: scarv_cop_mem_responder

Overview:
- Responder (slave) end of the COP memory interface: accepts `cop_mem_*` requests from `scarv_cop_top` and returns read data, stall and error.
- Backed by a local word-addressed memory array.
- Injects pseudo-random stall cycles from an LFSR, bounded by a run-time configuration input.
- Used as the memory model in simulation benches and formal harnesses around the COP.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0 of the window.
- DEPTH_LOG2, 10, window holds 2**DEPTH_LOG2 32-bit words.
- LFSR_SEED, 16'hACE1, reset value of the 16-bit stall LFSR; must be non-zero.

Ports:
- g_clk  in  1  global clock.
- g_reset  in  1  synchronous reset, active-high.
- cop_mem_cen  in  1  request valid / chip enable.
- cop_mem_wen  in  1  1 = write, 0 = read.
- cop_mem_addr  in  32  byte address; bits [1:0] ignored.
- cop_mem_wdata  in  32  write data.
- cop_mem_ben  in  4  byte enables; bit i covers wdata[8i+7:8i].
- cop_mem_rdata  out  32  read data, valid in finish cycle only.
- cop_mem_stall  out  1  response not yet ready.
- cop_mem_error  out  1  access error, valid in finish cycle only.
- cfg_stall_max  in  4  maximum stall cycles per transaction; 0 = no stalls.
- txn_count  out  32  count of completed transactions.

Behaviour:
- Reset values (g_reset=1 at a rising edge):
  - rdata=0, stall=0, error=0, txn_count=0.
  - LFSR=LFSR_SEED, state=IDLE, outstanding request dropped.
  - Memory array contents are not reset.
- States:
  - IDLE: no outstanding request.
  - WAIT: outstanding request, stall=1.
  - RESP: finish cycle, stall=0, rdata/error valid.
- Accept rule:
  - A request is accepted at a rising edge where cen=1 and state is IDLE or RESP.
  - Back-to-back: accept in the RESP cycle.
  - Accept latches addr[31:2], wen, wdata, ben.
  - Accept loads stall counter n = LFSR[3:0] mod (cfg_stall_max+1); LFSR steps once per accept (taps 16,14,13,11).
- Timing for a request accepted at edge ending cycle T:
  - Cycles T+1..T+n: WAIT, stall=1. Requester holds cen/addr/wdata/ben stable; the block does not re-sample them.
  - Cycle T+n+1: RESP. n=0 means response in T+1 (1-cycle latency).
  - RESP with cen=0 returns to IDLE; RESP with cen=1 accepts and goes to WAIT (n>0) or stays in RESP (n=0).
- In-range test: (addr[31:2] - BASE_ADDR[31:2]) < 2**DEPTH_LOG2, unsigned 30-bit subtraction. Addresses below BASE wrap and fail.
- Read, in range: rdata = mem[index] in the RESP cycle; rdata is registered, loaded on the edge entering RESP.
- Write, in range: bytes with ben=1 updated at the edge ending the RESP cycle; rdata=0 in RESP.
  - ben=4'b0000 writes nothing and is not an error.
- Out of range: error=1 and rdata=0 in RESP; writes suppressed; no other side effects.
- rdata=0 and error=0 in every non-RESP cycle.
- Read-after-write: when a read is accepted at the same edge a write commits, it returns the merged post-write word; a forwarding path is required.
- txn_count increments by 1 at each edge ending a RESP cycle, errored transactions included; wraps 2**32-1 -> 0.
- cfg_stall_max is sampled only at accept; changing it mid-transaction does not alter the current n.
- Reset mid-WAIT: transaction abandoned, no write performed, next cycle IDLE with stall=0.

Optional Feature:
- Macro: SCARV_MEM_RESP_FAULT_EN.
- Defined:
  - Adds input `fault_inject` (1 bit), sampled at accept.
  - If set, the transaction completes in RESP with error=1 regardless of range; the write is suppressed and rdata=0.
- Undefined:
  - Port absent.
  - Errors arise only from out-of-range addresses.

Decomposition:
- Shared package `scarv_cop_mem_pkg`: state encoding (IDLE/WAIT/RESP), LFSR tap constant, byte-lane width constant, in-range helper function.
- One sub-module, `scarv_cop_mem_stall_gen`: 16-bit LFSR plus down-counter; outputs stall and a counter-zero signal.
- Array, forwarding and FSM stay in the top.

Test Plan:
- cfg_stall_max=0; write 32'hDEADBEEF with ben=4'hF to BASE+0x10, then read BASE+0x10 -> each RESP one cycle after accept, stall never 1, read rdata=32'hDEADBEEF, txn_count=2.
- Word holds 32'h11223344; write ben=4'b0101, wdata=32'hAABBCCDD; read -> rdata=32'h11BB33DD.
- Back-to-back write then read to the same address with cfg_stall_max=0 -> read RESP returns the new data (forwarding exercised).
- cfg_stall_max=15; 100 random reads -> stall run length ≤15 per txn, cen/addr held stable by the bench, all data correct, txn_count=100.
- Read at BASE + 4*2**DEPTH_LOG2 and at BASE-4 -> error=1, rdata=0; subsequent read of an in-range word still correct.
- g_reset asserted during WAIT of a write to BASE+0 -> next cycle stall=0; a later read of BASE+0 returns the pre-write value; txn_count=0.
